// File: rtl/vend_ctrl.sv
// Vending-machine controller: coin credit, row/column selection, price lookup, dispense and change.
// Optional per-item stock tracking is built in when VEND_STOCK_EN is defined.
module vend_ctrl #(
    parameter  int N_ROWS      = 4,
    parameter  int N_COLS      = 4,
    parameter  int PRICE_W     = 16,
    parameter  int TIMEOUT_CYC = 1024,
    parameter  int STOCK_W     = 4,
    localparam int SEL_W       = $clog2(N_ROWS * N_COLS)
) (
    input  logic               I_CLK,
    input  logic               I_RESET_N,
    input  logic [N_ROWS-1:0]  I_ROW,
    input  logic [N_COLS-1:0]  I_COL,
    input  logic               I_COIN_VALID,
    input  logic [PRICE_W-1:0] I_COIN_VALUE,
    input  logic               I_CANCEL,
    input  logic               I_CFG_WE,
    input  logic [SEL_W-1:0]   I_CFG_ADDR,
    input  logic [PRICE_W-1:0] I_CFG_PRICE,
    input  logic [STOCK_W-1:0] I_CFG_STOCK,
    output logic [PRICE_W-1:0] O_CREDIT,
    output logic [PRICE_W-1:0] O_PRICE,
    output logic [SEL_W-1:0]   O_SEL,
    output logic               O_SUCCESS,
    output logic [PRICE_W-1:0] O_CHANGE,
    output logic               O_CHANGE_VALID,
    output logic               O_SOLD_OUT
);
    // state         | meaning
    // S_IDLE        | no selection in progress
    // S_ROW         | letter latched, waiting for number
    // S_CHECK       | price/stock lookup of the selection
    // S_WAIT_CREDIT | selection priced, credit short
    // S_DISPENSE    | item released, price deducted
    // S_GIVE_CHANGE | remaining credit paid out
    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_ROW         = 3'd1;
    localparam logic [2:0] S_CHECK       = 3'd2;
    localparam logic [2:0] S_WAIT_CREDIT = 3'd3;
    localparam logic [2:0] S_DISPENSE    = 3'd4;
    localparam logic [2:0] S_GIVE_CHANGE = 3'd5;

    localparam int N_ITEMS = N_ROWS * N_COLS;
    localparam int RW      = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int CW      = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC);

    logic [2:0]         state_q, state_d;
    logic [RW-1:0]      row_q, row_d, row_idx;
    logic [CW-1:0]      col_q, col_d, col_idx;
    logic [PRICE_W-1:0] credit_q, credit_d, credit_inc, coin;
    logic [PRICE_W-1:0] price_o_q, price_o_d;
    logic [SEL_W-1:0]   sel_o_q, sel_o_d, sel;
    logic               success_q, success_d;
    logic [PRICE_W-1:0] change_q, change_d;
    logic               change_vld_q, change_vld_d;
    logic               sold_out_d, sold_hit;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               row_vld, col_vld, btn_any, in_cnt, timeout, abort;
    logic [PRICE_W-1:0] price_tbl_q [N_ITEMS];
    logic [PRICE_W-1:0] sel_price;

    function automatic logic [PRICE_W-1:0] sat_add(input logic [PRICE_W-1:0] a,
                                                   input logic [PRICE_W-1:0] b);
        logic [PRICE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[PRICE_W] ? '1 : s[PRICE_W-1:0];
    endfunction

    always_comb begin
        row_idx = '0;
        for (int i = 0; i < N_ROWS; i++) if (I_ROW[i]) row_idx = RW'(i);
        col_idx = '0;
        for (int i = 0; i < N_COLS; i++) if (I_COL[i]) col_idx = CW'(i);
    end

    assign row_vld    = $onehot(I_ROW);
    assign col_vld    = $onehot(I_COL);
    assign btn_any    = (|I_ROW) | (|I_COL);
    assign coin       = I_COIN_VALID ? I_COIN_VALUE : '0;
    assign credit_inc = sat_add(credit_q, coin);
    assign sel        = SEL_W'(int'(row_q) * N_COLS + int'(col_q));
    assign sel_price  = price_tbl_q[sel];

    // Timeout fires on the cycle that would otherwise take the counter to zero.
    assign in_cnt  = (state_q == S_ROW) || (state_q == S_WAIT_CREDIT);
    assign timeout = in_cnt && (tmo_q == TW'(1)) && !btn_any && !I_COIN_VALID;
    assign abort   = I_CANCEL || timeout;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        credit_d     = credit_inc;
        price_o_d    = price_o_q;
        sel_o_d      = sel_o_q;
        success_d    = 1'b0;
        change_d     = change_q;
        change_vld_d = 1'b0;
        sold_out_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (abort) begin
                    state_d = (credit_inc != '0) ? S_GIVE_CHANGE : S_IDLE;
                end else if (row_vld) begin
                    row_d   = row_idx;
                    state_d = S_ROW;
                end
            end
            S_ROW: begin
                if (abort) begin
                    state_d = (credit_inc != '0) ? S_GIVE_CHANGE : S_IDLE;
                end else if (row_vld) begin
                    row_d = row_idx;
                end else if (col_vld) begin
                    col_d   = col_idx;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                price_o_d = sel_price;
                if (sold_hit) begin
                    sold_out_d = 1'b1;
                    state_d    = S_ROW;
                end else if (credit_q >= sel_price) begin
                    state_d = S_DISPENSE;
                end else begin
                    state_d = S_WAIT_CREDIT;
                end
            end
            S_WAIT_CREDIT: begin
                if (abort) begin
                    state_d = (credit_inc != '0) ? S_GIVE_CHANGE : S_IDLE;
                end else if (credit_q >= price_o_q) begin
                    state_d = S_DISPENSE;
                end else if (row_vld) begin
                    row_d   = row_idx;
                    state_d = S_ROW;
                end
            end
            S_DISPENSE: begin
                sel_o_d   = sel;
                success_d = 1'b1;
                credit_d  = sat_add(credit_q - price_o_q, coin);
                state_d   = (credit_d == '0) ? S_IDLE : S_GIVE_CHANGE;
            end
            S_GIVE_CHANGE: begin
                change_d     = credit_inc;
                change_vld_d = 1'b1;
                credit_d     = '0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        if (!in_cnt || btn_any || I_COIN_VALID || (state_d != state_q)) tmo_d = TMO_LOAD;
        else tmo_d = tmo_q - TW'(1);
    end

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            credit_q     <= '0;
            price_o_q    <= '0;
            sel_o_q      <= '0;
            success_q    <= 1'b0;
            change_q     <= '0;
            change_vld_q <= 1'b0;
            tmo_q        <= TMO_LOAD;
            for (int i = 0; i < N_ITEMS; i++) price_tbl_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            credit_q     <= credit_d;
            price_o_q    <= price_o_d;
            sel_o_q      <= sel_o_d;
            success_q    <= success_d;
            change_q     <= change_d;
            change_vld_q <= change_vld_d;
            tmo_q        <= tmo_d;
            for (int i = 0; i < N_ITEMS; i++)
                if (I_CFG_WE && (I_CFG_ADDR == SEL_W'(i))) price_tbl_q[i] <= I_CFG_PRICE;
        end
    end

`ifdef VEND_STOCK_EN
    logic [STOCK_W-1:0] stock_tbl_q [N_ITEMS];
    logic               sold_out_q;

    assign sold_hit   = (stock_tbl_q[sel] == '0);
    assign O_SOLD_OUT = sold_out_q;

    // A config write wins over the dispense decrement on the same entry.
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            sold_out_q <= 1'b0;
            for (int i = 0; i < N_ITEMS; i++) stock_tbl_q[i] <= '0;
        end else begin
            sold_out_q <= sold_out_d;
            for (int i = 0; i < N_ITEMS; i++) begin
                if (I_CFG_WE && (I_CFG_ADDR == SEL_W'(i)))
                    stock_tbl_q[i] <= I_CFG_STOCK;
                else if ((state_q == S_DISPENSE) && (sel == SEL_W'(i)) && (stock_tbl_q[i] != '0))
                    stock_tbl_q[i] <= stock_tbl_q[i] - STOCK_W'(1);
            end
        end
    end
`else
    logic unused_stock;
    assign unused_stock = ^{I_CFG_STOCK, sold_out_d};
    assign sold_hit     = 1'b0;
    assign O_SOLD_OUT   = 1'b0;
`endif

    assign O_CREDIT       = credit_q;
    assign O_PRICE        = price_o_q;
    assign O_SEL          = sel_o_q;
    assign O_SUCCESS      = success_q;
    assign O_CHANGE       = change_q;
    assign O_CHANGE_VALID = change_vld_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: scoreboard of dispense/change/sold-out events plus inline checks.
module tb_vend_ctrl;
    localparam int TMO = 64;
    localparam logic [1:0] K_SUCC = 2'd1;
    localparam logic [1:0] K_CHG  = 2'd2;
    localparam logic [1:0] K_SOLD = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] val;
    } ev_t;

    logic        I_CLK = 1'b0;
    logic        I_RESET_N = 1'b0;
    logic [3:0]  I_ROW = '0;
    logic [3:0]  I_COL = '0;
    logic        I_COIN_VALID = 1'b0;
    logic [15:0] I_COIN_VALUE = '0;
    logic        I_CANCEL = 1'b0;
    logic        I_CFG_WE = 1'b0;
    logic [3:0]  I_CFG_ADDR = '0;
    logic [15:0] I_CFG_PRICE = '0;
    logic [3:0]  I_CFG_STOCK = '0;
    logic [15:0] O_CREDIT, O_PRICE, O_CHANGE;
    logic [3:0]  O_SEL;
    logic        O_SUCCESS, O_CHANGE_VALID, O_SOLD_OUT;

    int  n_vec = 0;
    int  n_err = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    vend_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .I_CLK(I_CLK), .I_RESET_N(I_RESET_N), .I_ROW(I_ROW), .I_COL(I_COL),
        .I_COIN_VALID(I_COIN_VALID), .I_COIN_VALUE(I_COIN_VALUE), .I_CANCEL(I_CANCEL),
        .I_CFG_WE(I_CFG_WE), .I_CFG_ADDR(I_CFG_ADDR), .I_CFG_PRICE(I_CFG_PRICE),
        .I_CFG_STOCK(I_CFG_STOCK), .O_CREDIT(O_CREDIT), .O_PRICE(O_PRICE), .O_SEL(O_SEL),
        .O_SUCCESS(O_SUCCESS), .O_CHANGE(O_CHANGE), .O_CHANGE_VALID(O_CHANGE_VALID),
        .O_SOLD_OUT(O_SOLD_OUT)
    );

    always #5 I_CLK = ~I_CLK;

    // Output monitor: records every DUT event for the scoreboard.
    always @(negedge I_CLK) begin
        if (I_RESET_N) begin
            if (O_SUCCESS)      obs_q.push_back('{K_SUCC, {12'd0, O_SEL}});
            if (O_CHANGE_VALID) obs_q.push_back('{K_CHG, O_CHANGE});
            if (O_SOLD_OUT)     obs_q.push_back('{K_SOLD, 16'd0});
        end
    end

    task automatic step();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic press_row(input int r);
        I_ROW = 4'(1 << r);
        step();
        I_ROW = '0;
    endtask

    task automatic press_col(input int c);
        I_COL = 4'(1 << c);
        step();
        I_COL = '0;
    endtask

    task automatic coin(input int v);
        I_COIN_VALID = 1'b1;
        I_COIN_VALUE = 16'(v);
        step();
        I_COIN_VALID = 1'b0;
        I_COIN_VALUE = '0;
    endtask

    task automatic cancel();
        I_CANCEL = 1'b1;
        step();
        I_CANCEL = 1'b0;
    endtask

    task automatic cfg(input int addr, input int price, input int stock);
        I_CFG_WE    = 1'b1;
        I_CFG_ADDR  = 4'(addr);
        I_CFG_PRICE = 16'(price);
        I_CFG_STOCK = 4'(stock);
        step();
        I_CFG_WE = 1'b0;
    endtask

    task automatic load_table();
        cfg(0, 100, 5);
        cfg(5, 250, 5);
        cfg(8, 150, 1);
        cfg(15, 200, 5);
    endtask

    // Pairs expected events with observed ones in order; leftovers on either side are errors.
    task automatic sb_drain(input string name);
        ev_t e, o;
        for (int i = 0; i < 64 && obs_q.size() < exp_q.size(); i++) step();
        repeat (4) step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL %s: no event seen, expected kind=%0d val=%0d", name, e.kind, e.val);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL %s: got kind=%0d val=%0d, expected kind=%0d val=%0d",
                             name, o.kind, o.val, e.kind, e.val);
                end
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s: unexpected event kind=%0d val=%0d", name, o.kind, o.val);
        end
    endtask

    task automatic test_reset();
        I_RESET_N = 1'b0;
        repeat (3) step();
        n_vec++;
        if ({O_CREDIT, O_PRICE, O_CHANGE, O_SEL, O_SUCCESS, O_CHANGE_VALID, O_SOLD_OUT} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got credit=%0d price=%0d change=%0d sel=%0d flags=%b%b%b, expected all 0",
                     O_CREDIT, O_PRICE, O_CHANGE, O_SEL, O_SUCCESS, O_CHANGE_VALID, O_SOLD_OUT);
        end
        I_RESET_N = 1'b1;
        step();
    endtask

    task automatic test_exact_buy();
        repeat (4) coin(25);
        n_vec++;
        if (O_CREDIT !== 16'd100) begin
            n_err++;
            $display("FAIL exact_credit: got %0d, expected 100", O_CREDIT);
        end
        exp_q.push_back('{K_SUCC, 16'd0});
        press_row(0);
        press_col(0);
        step();
        n_vec++;
        if (O_PRICE !== 16'd100 || O_SUCCESS !== 1'b0) begin
            n_err++;
            $display("FAIL exact_price_edge1: got price=%0d success=%b, expected 100/0", O_PRICE, O_SUCCESS);
        end
        step();
        n_vec++;
        if (O_SUCCESS !== 1'b1 || O_SEL !== 4'd0) begin
            n_err++;
            $display("FAIL exact_success_edge2: got success=%b sel=%0d, expected 1/0", O_SUCCESS, O_SEL);
        end
        sb_drain("exact_buy");
        n_vec++;
        if (O_CREDIT !== 16'd0) begin
            n_err++;
            $display("FAIL exact_credit_after: got %0d, expected 0", O_CREDIT);
        end
    endtask

    task automatic test_wait_credit();
        coin(100);
        coin(100);
        press_row(1);
        press_col(1);
        repeat (3) step();
        n_vec++;
        if (O_PRICE !== 16'd250 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL wait_short: got price=%0d events=%0d, expected 250/0", O_PRICE, obs_q.size());
        end
        exp_q.push_back('{K_SUCC, 16'd5});
        coin(50);
        sb_drain("wait_credit");
        n_vec++;
        if (O_CREDIT !== 16'd0) begin
            n_err++;
            $display("FAIL wait_credit_after: got %0d, expected 0", O_CREDIT);
        end
    endtask

    task automatic test_change();
        repeat (4) coin(100);
        exp_q.push_back('{K_SUCC, 16'd15});
        exp_q.push_back('{K_CHG, 16'd200});
        press_row(0);
        press_row(1);
        press_row(3);
        press_col(3);
        sb_drain("change");
        n_vec++;
        if (O_PRICE !== 16'd200 || O_CREDIT !== 16'd0) begin
            n_err++;
            $display("FAIL change_after: got price=%0d credit=%0d, expected 200/0", O_PRICE, O_CREDIT);
        end
    endtask

    // Multi-bit presses ignored, column ignored in idle, row wins over column in the same cycle.
    task automatic test_ignore();
        coin(100);
        I_ROW = 4'b0011;
        step();
        I_ROW = '0;
        press_col(0);
        press_row(0);
        I_ROW = 4'b0010;
        I_COL = 4'b0001;
        step();
        I_ROW = '0;
        I_COL = '0;
        exp_q.push_back('{K_SUCC, 16'd4});
        exp_q.push_back('{K_CHG, 16'd100});
        press_col(0);
        sb_drain("ignore");
    endtask

    task automatic test_timeout();
        int n;
        repeat (3) coin(25);
        exp_q.push_back('{K_CHG, 16'd75});
        press_row(2);
        n = 0;
        while (O_CHANGE_VALID !== 1'b1 && n < TMO + 20) begin
            step();
            n++;
        end
        n_vec++;
        if (n != TMO + 1) begin
            n_err++;
            $display("FAIL timeout_latency: got %0d cycles, expected %0d", n, TMO + 1);
        end
        sb_drain("timeout");
        n_vec++;
        if (O_CREDIT !== 16'd0) begin
            n_err++;
            $display("FAIL timeout_credit: got %0d, expected 0", O_CREDIT);
        end
    endtask

    task automatic test_cancel();
        repeat (3) coin(25);
        press_row(2);
        repeat (3) step();
        exp_q.push_back('{K_CHG, 16'd75});
        cancel();
        step();
        n_vec++;
        if (O_CHANGE_VALID !== 1'b1 || O_CHANGE !== 16'd75) begin
            n_err++;
            $display("FAIL cancel_edge: got valid=%b change=%0d, expected 1/75", O_CHANGE_VALID, O_CHANGE);
        end
        sb_drain("cancel");
    endtask

    task automatic test_saturate();
        coin(65500);
        coin(500);
        n_vec++;
        if (O_CREDIT !== 16'd65535) begin
            n_err++;
            $display("FAIL saturate: got %0d, expected 65535", O_CREDIT);
        end
        exp_q.push_back('{K_CHG, 16'd65535});
        cancel();
        sb_drain("saturate_refund");
    endtask

    task automatic test_reset_mid();
        coin(100);
        coin(50);
        press_row(3);
        press_col(3);
        repeat (2) step();
        I_RESET_N = 1'b0;
        #2;
        n_vec++;
        if ({O_CREDIT, O_PRICE, O_CHANGE, O_SEL, O_SUCCESS, O_CHANGE_VALID, O_SOLD_OUT} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got credit=%0d price=%0d change=%0d sel=%0d, expected all 0",
                     O_CREDIT, O_PRICE, O_CHANGE, O_SEL);
        end
        step();
        I_RESET_N = 1'b1;
        step();
        load_table();
        press_row(3);
        press_col(3);
        repeat (3) step();
        n_vec++;
        if (O_PRICE !== 16'd200 || O_CREDIT !== 16'd0) begin
            n_err++;
            $display("FAIL reset_mid_after: got price=%0d credit=%0d, expected 200/0", O_PRICE, O_CREDIT);
        end
        cancel();
        sb_drain("reset_mid_no_dispense");
    endtask

    task automatic test_stock();
        coin(100);
        coin(50);
        exp_q.push_back('{K_SUCC, 16'd8});
        press_row(2);
        press_col(0);
        sb_drain("stock_first");
        coin(100);
        coin(50);
`ifdef VEND_STOCK_EN
        exp_q.push_back('{K_SOLD, 16'd0});
        press_row(2);
        press_col(0);
        sb_drain("stock_sold_out");
        n_vec++;
        if (O_CREDIT !== 16'd150) begin
            n_err++;
            $display("FAIL stock_credit_kept: got %0d, expected 150", O_CREDIT);
        end
        exp_q.push_back('{K_CHG, 16'd150});
        cancel();
        sb_drain("stock_refund");
`else
        exp_q.push_back('{K_SUCC, 16'd8});
        press_row(2);
        press_col(0);
        sb_drain("stock_second");
        n_vec++;
        if (O_CREDIT !== 16'd0) begin
            n_err++;
            $display("FAIL stock_second_credit: got %0d, expected 0", O_CREDIT);
        end
`endif
    endtask

    initial begin
        test_reset();
        load_table();
        test_exact_buy();
        test_wait_credit();
        test_change();
        test_ignore();
        test_timeout();
        test_cancel();
        test_saturate();
        test_reset_mid();
        test_stock();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Parametrised, clocked vending-machine controller: accepts coin credit and a letter/number selection over an N_ROWS × N_COLS item grid. Looks up the item price in a runtime-loadable price table, dispenses when credit suffices, and returns change. Cancel and an inactivity timeout refund the credit. It sits between the debounced front-panel/coin-acceptor logic and the dispenser/change-hopper drivers.

## Interface
- N_ROWS, 4, number of letter buttons (A = row 0).
- N_COLS, 4, number of number buttons ("1" = col 0).
- PRICE_W, 16, width of credit, price and change (cents).
- TIMEOUT_CYC, 1024, idle cycles before auto-cancel.
- STOCK_W, 4, per-item stock counter width (used only with VEND_STOCK_EN).
- Derived: SEL_W = $clog2(N_ROWS*N_COLS); selection index = row*N_COLS + col (A1 = 0; D4 = 15 at defaults).
- One clock. Reset is asynchronous and active-low.
- I_CLK  in  1  clock; all state changes on its rising edge.
- I_RESET_N  in  1  asynchronous, active-low reset.
- I_ROW  in  N_ROWS  letter buttons, one-cycle pulses.
- I_COL  in  N_COLS  number buttons, one-cycle pulses.
- I_COIN_VALID  in  1  coin accepted this cycle.
- I_COIN_VALUE  in  PRICE_W  coin value; qualified by I_COIN_VALID.
- I_CANCEL  in  1  refund request pulse.
- I_CFG_WE  in  1  price/stock table write strobe.
- I_CFG_ADDR  in  SEL_W  table index.
- I_CFG_PRICE  in  PRICE_W  price written on I_CFG_WE.
- I_CFG_STOCK  in  STOCK_W  stock written on I_CFG_WE.
- O_CREDIT  out  PRICE_W  current credit.
- O_PRICE  out  PRICE_W  price of the last checked selection.
- O_SEL  out  SEL_W  dispensed item index.
- O_SUCCESS  out  1  one-cycle pulse per dispense.
- O_CHANGE  out  PRICE_W  change amount; qualified by O_CHANGE_VALID.
- O_CHANGE_VALID  out  1  one-cycle pulse.
- O_SOLD_OUT  out  1  one-cycle pulse.

## Operation
- Reset: state S_IDLE; credit, all outputs, all price and stock entries cleared to 0.
- Button input with more than one bit set is ignored entirely.
- Coins add to credit in every state. Credit saturates at 2^PRICE_W−1.
- S_IDLE: a row press latches the row and moves to S_ROW. A column press is ignored.
- S_ROW:
  - A new row press relatches the row; the last letter wins.
  - A column press latches the column and moves to S_CHECK.
  - A row and a column in the same cycle: the row is relatched and the column is ignored.
- S_CHECK (1 cycle): O_PRICE <= price[sel].
  - If credit ≥ price: go to S_DISPENSE.
  - Otherwise: go to S_WAIT_CREDIT.
- S_WAIT_CREDIT:
  - Each cycle, if credit ≥ O_PRICE: go to S_DISPENSE.
  - A row press relatches the row and returns to S_ROW.
- S_DISPENSE (1 cycle):
  - O_SEL <= sel; O_SUCCESS pulses.
  - credit <= credit − price + (coin this cycle).
  - If the result is zero: go to S_IDLE; otherwise: go to S_GIVE_CHANGE.
- S_GIVE_CHANGE (1 cycle):
  - O_CHANGE <= credit + (coin this cycle); O_CHANGE_VALID pulses.
  - credit <= 0; go to S_IDLE.
- Cancel is honoured in S_IDLE, S_ROW and S_WAIT_CREDIT. It goes to S_GIVE_CHANGE if credit ≠ 0, otherwise to S_IDLE. The selection is discarded.
- Cancel is ignored in S_CHECK, S_DISPENSE and S_GIVE_CHANGE.
- Timeout counter:
  - Cleared by any button, coin or state change.
  - Counts while in S_ROW or S_WAIT_CREDIT.
  - Reaching TIMEOUT_CYC acts as cancel.
- Table writes are allowed at any time. A write to the index being checked in the same cycle yields the old value.

## Timing
- All outputs are registered.
- Column press sampled at edge 0 → S_CHECK.
- Edge 1 → O_PRICE valid.
- Edge 2 → O_SUCCESS = 1 and O_SEL valid.
- Edge 3 → O_CHANGE_VALID = 1.
- Cancel/timeout at edge n → O_CHANGE_VALID at edge n+1.
- O_CREDIT reflects a coin one cycle after I_COIN_VALID.
- Asynchronous reset takes effect immediately, mid-transaction included. Any credit held is discarded.

## Configuration
- VEND_STOCK_EN defined:
  - Per-item stock registers (reset 0), loaded with I_CFG_STOCK on I_CFG_WE.
  - In S_CHECK, stock == 0 pulses O_SOLD_OUT and returns to S_ROW with credit kept.
  - S_DISPENSE decrements the item's stock.
- VEND_STOCK_EN undefined:
  - No stock storage; I_CFG_STOCK is ignored; O_SOLD_OUT is tied 0.
  - Items are never sold out.

## Test plan
- Load A1=100, B2=250, C1=150, D4=200; coins 25×4; press A,1 → O_SUCCESS pulse, O_SEL=0, no O_CHANGE_VALID, O_CREDIT=0.
- Coins 100,100; press B,2 → O_PRICE=250, no success. Coin 50 → O_SUCCESS, O_SEL=5, no change.
- Credit 400; press A,B,D,4 → O_SEL=15, O_SUCCESS, then O_CHANGE=200 with O_CHANGE_VALID.
- Credit 75; press C; idle for TIMEOUT_CYC cycles → O_CHANGE=75, state S_IDLE. Repeat using I_CANCEL → same response one cycle after the pulse.
- Edge cases:
  - Credit 65500 plus a 500 coin → O_CREDIT=65535.
  - I_RESET_N low in S_WAIT_CREDIT with credit 150 → all outputs 0 at once; after release, press D,4 → no dispense.
- VEND_STOCK_EN with C1 stock=1: two C,1 purchases at credit 150 each → first O_SUCCESS; second O_SOLD_OUT with O_CREDIT=150 kept. Without the macro, both succeed.
